// File: rtl/clkgen_prog_ctrl.sv
// Programs M/D values into DCM_CLKGEN channels over the shared PROGEN/PROGDATA
// serial port, then waits for PROGDONE and LOCKED with a per-state timeout.
module clkgen_prog_ctrl #(
  parameter int NUM_CH  = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [1:0]        ch_sel_i,
  input  logic [7:0]        mult_i,
  input  logic [7:0]        div_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [NUM_CH-1:0] progen_o,
  output logic              progdata_o,
  input  logic [NUM_CH-1:0] progdone_i,
  input  logic [NUM_CH-1:0] locked_i
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] CHK       = 4'd1;
  localparam logic [3:0] LOAD_D    = 4'd2;
  localparam logic [3:0] GAP1      = 4'd3;
  localparam logic [3:0] LOAD_M    = 4'd4;
  localparam logic [3:0] GAP2      = 4'd5;
  localparam logic [3:0] GO        = 4'd6;
  localparam logic [3:0] WAIT_DONE = 4'd7;
  localparam logic [3:0] WAIT_LOCK = 4'd8;

  localparam logic [2:0]  NUM_CH_W = 3'(NUM_CH);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]        rstSync_q;
  logic [3:0]        state_q, state_d;
  logic [1:0]        chSel_q, chSel_d;
  logic [7:0]        mult_q, mult_d;
  logic [7:0]        div_q, div_d;
  logic [3:0]        bitCnt_q, bitCnt_d;
  logic [9:0]        shift_q, shift_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [1:0]        errCode_q, errCode_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] progen_q, progen_d;
  logic              progdata_q, progdata_d;
  logic [NUM_CH-1:0] chMask;
  logic              progdoneHit;
  logic              lockedHit;

  // Reset is asserted asynchronously but released only after two clock edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rstSync_q <= 2'b00;
    else         rstSync_q <= {rstSync_q[0], 1'b1};
  end

  always_comb begin
    chMask = '0;
    for (int i = 0; i < NUM_CH; i++) chMask[i] = (chSel_q == 2'(i));
    progdoneHit = |(progdone_i & chMask);
    lockedHit   = |(locked_i & chMask);
  end

  always_comb begin
    state_d   = state_q;
    chSel_d   = chSel_q;
    mult_d    = mult_q;
    div_d     = div_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    errCode_d = errCode_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i && rstSync_q[1]) begin
          chSel_d   = ch_sel_i;
          mult_d    = mult_i;
          div_d     = div_i;
          errCode_d = 2'd0;
          state_d   = CHK;
        end
      end
      CHK: begin
        if (mult_q < 8'd2 || div_q == 8'd0 || {1'b0, chSel_q} >= NUM_CH_W) begin
          err_d     = 1'b1;
          errCode_d = 2'd1;
          state_d   = IDLE;
        end else begin
          // Shifted out LSB first: header 1,0 then D-1
          shift_d  = {div_q - 8'd1, 2'b01};
          bitCnt_d = 4'd0;
          state_d  = LOAD_D;
        end
      end
      LOAD_D: begin
        shift_d  = {1'b0, shift_q[9:1]};
        bitCnt_d = bitCnt_q + 4'd1;
        if (bitCnt_q == 4'd9) state_d = GAP1;
      end
      GAP1: begin
        shift_d  = {mult_q - 8'd1, 2'b11};
        bitCnt_d = 4'd0;
        state_d  = LOAD_M;
      end
      LOAD_M: begin
        shift_d  = {1'b0, shift_q[9:1]};
        bitCnt_d = bitCnt_q + 4'd1;
        if (bitCnt_q == 4'd9) state_d = GAP2;
      end
      GAP2: state_d = GO;
      GO: begin
        tmo_d   = 16'd0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (progdoneHit) begin
          tmo_d   = 16'd0;
          state_d = WAIT_LOCK;
        end else if (tmo_q == TMO_LAST) begin
          err_d     = 1'b1;
          errCode_d = 2'd2;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      WAIT_LOCK: begin
        if (lockedHit) begin
          done_d    = 1'b1;
          errCode_d = 2'd0;
          state_d   = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d     = 1'b1;
          errCode_d = 2'd3;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    busy_d     = (state_d != IDLE);
    progen_d   = (state_d == LOAD_D || state_d == LOAD_M || state_d == GO) ? chMask : '0;
    progdata_d = (state_d == LOAD_D || state_d == LOAD_M) ? shift_d[0] : 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      chSel_q    <= 2'd0;
      mult_q     <= 8'd0;
      div_q      <= 8'd0;
      bitCnt_q   <= 4'd0;
      shift_q    <= 10'd0;
      tmo_q      <= 16'd0;
      errCode_q  <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      progen_q   <= '0;
      progdata_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      chSel_q    <= chSel_d;
      mult_q     <= mult_d;
      div_q      <= div_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
      errCode_q  <= errCode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      progen_q   <= progen_d;
      progdata_q <= progdata_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = errCode_q;
  assign progen_o   = progen_q;
  assign progdata_o = progdata_q;

endmodule

// File: tb/tb_clkgen_prog_ctrl.sv
// Scoreboard bench for clkgen_prog_ctrl: expected completion pulses and serial
// bits are queued by the stimulus and popped by independent monitors.
module tb_clkgen_prog_ctrl;

  localparam int NUM_CH  = 2;
  localparam int TIMEOUT = 100;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic [1:0]  ch_sel_i;
  logic [7:0]  mult_i;
  logic [7:0]  div_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [1:0]  progen_o;
  logic        progdata_o;
  logic [1:0]  progdone_i;
  logic [1:0]  locked_i;

  int cycleCnt    = 0;
  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    int         cyc;
    logic       isErr;
    logic [1:0] code;
  } evt_t;

  typedef struct {
    int         cyc;
    logic [1:0] en;
    logic       data;
  } bit_t;

  evt_t evtQ[$];
  bit_t bitQ[$];
  evt_t curEvt;
  bit_t curBit;

  // Hand-derived serial streams, first transmitted bit on the left.
  localparam logic [9:0] D_DIV8   = 10'b1011100000;
  localparam logic [9:0] M_MUL35  = 10'b1101000100;
  localparam logic [9:0] D_DIV1   = 10'b1000000000;
  localparam logic [9:0] M_MUL2   = 10'b1110000000;
  localparam logic [9:0] D_DIV255 = 10'b1001111111;
  localparam logic [9:0] M_MUL255 = 10'b1101111111;
  localparam logic [9:0] D_DIV3   = 10'b1001000000;
  localparam logic [9:0] M_MUL4   = 10'b1111000000;

  clkgen_prog_ctrl #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .ch_sel_i   (ch_sel_i),
    .mult_i     (mult_i),
    .div_i      (div_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_code_o (err_code_o),
    .progen_o   (progen_o),
    .progdata_o (progdata_o),
    .progdone_i (progdone_i),
    .locked_i   (locked_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  task automatic waitUntil(input int target);
    while (cycleCnt < target) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Drives a one-cycle request; must be entered just after a rising edge.
  task automatic applyStimulus(input logic [1:0] ch, input logic [7:0] m, input logic [7:0] d, output int c);
    ch_sel_i = ch;
    mult_i   = m;
    div_i    = d;
    req_i    = 1'b1;
    c        = cycleCnt;
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
  endtask

  task automatic pushEvt(input int cyc, input logic isErr, input logic [1:0] code);
    evt_t e;
    e.cyc   = cyc;
    e.isErr = isErr;
    e.code  = code;
    evtQ.push_back(e);
  endtask

  task automatic pushStream(input int c, input logic [1:0] ch, input logic [9:0] dSeq,
                            input logic [9:0] mSeq, input int nD);
    bit_t b;
    b.en = 2'b01 << ch;
    for (int i = 0; i < nD; i++) begin
      b.cyc  = c + 2 + i;
      b.data = dSeq[9-i];
      bitQ.push_back(b);
    end
    if (nD == 10) begin
      for (int i = 0; i < 10; i++) begin
        b.cyc  = c + 13 + i;
        b.data = mSeq[9-i];
        bitQ.push_back(b);
      end
      b.cyc  = c + 24;
      b.data = 1'b0;
      bitQ.push_back(b);
    end
  endtask

  // Completion monitor: every DONE/ERR pulse must match the next queued event.
  always @(negedge clk_i) begin
    if (done_o === 1'b1 || err_o === 1'b1) begin
      if (evtQ.size() == 0) begin
        checkOutput("unexpected_pulse", {30'd0, done_o, err_o}, 32'd0);
      end else begin
        curEvt = evtQ.pop_front();
        checkOutput("evt_cycle", cycleCnt, curEvt.cyc);
        checkOutput("evt_err", {31'd0, err_o}, {31'd0, curEvt.isErr});
        checkOutput("evt_done", {31'd0, done_o}, {31'd0, ~curEvt.isErr});
        checkOutput("evt_code", {30'd0, err_code_o}, {30'd0, curEvt.code});
        checkOutput("evt_busy_low", {31'd0, busy_o}, 32'd0);
      end
    end
  end

  // Serial monitor: every cycle with PROGEN active must match the next queued bit.
  always @(negedge clk_i) begin
    if (progen_o !== 2'b00) begin
      if (bitQ.size() == 0) begin
        checkOutput("unexpected_progen", {30'd0, progen_o}, 32'd0);
      end else begin
        curBit = bitQ.pop_front();
        checkOutput("bit_cycle", cycleCnt, curBit.cyc);
        checkOutput("bit_progen", {30'd0, progen_o}, {30'd0, curBit.en});
        checkOutput("bit_data", {31'd0, progdata_o}, {31'd0, curBit.data});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    int c;
    int c2;
    rst_ni     = 1'b0;
    req_i      = 1'b0;
    ch_sel_i   = 2'd0;
    mult_i     = 8'd0;
    div_i      = 8'd0;
    progdone_i = 2'b00;
    locked_i   = 2'b00;

    // Reset values
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    checkOutput("rst_err", {31'd0, err_o}, 32'd0);
    checkOutput("rst_code", {30'd0, err_code_o}, 32'd0);
    checkOutput("rst_progen", {30'd0, progen_o}, 32'd0);
    checkOutput("rst_progdata", {31'd0, progdata_o}, 32'd0);

    // Release with REQ already high: accepted only on the third edge; MULT=1 is illegal
    @(posedge clk_i);
    #1;
    r        = cycleCnt;
    ch_sel_i = 2'd0;
    mult_i   = 8'd1;
    div_i    = 8'd8;
    req_i    = 1'b1;
    #1 rst_ni = 1'b1;
    pushEvt(r + 4, 1'b1, 2'd1);
    waitUntil(r + 1);
    @(negedge clk_i);
    checkOutput("sync_busy_1", {31'd0, busy_o}, 32'd0);
    waitUntil(r + 2);
    @(negedge clk_i);
    checkOutput("sync_busy_2", {31'd0, busy_o}, 32'd0);
    waitUntil(r + 3);
    req_i = 1'b0;
    @(negedge clk_i);
    checkOutput("sync_busy_3", {31'd0, busy_o}, 32'd1);
    waitUntil(r + 6);
    checkOutput("code_held", {30'd0, err_code_o}, 32'd1);

    // Main program: CH1, M=35, D=8, PROGDONE 5 after GO, LOCKED 20 later
    applyStimulus(2'd1, 8'd35, 8'd8, c);
    checkOutput("accept_busy", {31'd0, busy_o}, 32'd1);
    checkOutput("accept_code_clr", {30'd0, err_code_o}, 32'd0);
    pushStream(c, 2'd1, D_DIV8, M_MUL35, 10);
    pushEvt(c + 50, 1'b0, 2'd0);
    waitUntil(c + 29);
    progdone_i = 2'b10;
    waitUntil(c + 49);
    locked_i = 2'b10;
    waitUntil(c + 51);

    // Back-to-back request at DONE+1 with minimum legal M and D
    progdone_i = 2'b11;
    locked_i   = 2'b11;
    applyStimulus(2'd0, 8'd2, 8'd1, c2);
    pushStream(c2, 2'd0, D_DIV1, M_MUL2, 10);
    pushEvt(c2 + 27, 1'b0, 2'd0);
    waitUntil(c2 + 30);
    progdone_i = 2'b00;
    locked_i   = 2'b00;

    // Illegal D and illegal channel
    applyStimulus(2'd0, 8'd35, 8'd0, c);
    pushEvt(c + 2, 1'b1, 2'd1);
    waitUntil(c + 4);
    applyStimulus(2'd2, 8'd35, 8'd8, c);
    pushEvt(c + 2, 1'b1, 2'd1);
    waitUntil(c + 4);

    // PROGDONE never arrives: timeout 100 cycles after WAIT_DONE entry
    applyStimulus(2'd1, 8'd255, 8'd255, c);
    pushStream(c, 2'd1, D_DIV255, M_MUL255, 10);
    pushEvt(c + 125, 1'b1, 2'd2);
    waitUntil(c + 127);

    // PROGDONE present, LOCKED never arrives
    progdone_i = 2'b01;
    locked_i   = 2'b00;
    applyStimulus(2'd0, 8'd4, 8'd3, c);
    pushStream(c, 2'd0, D_DIV3, M_MUL4, 10);
    pushEvt(c + 126, 1'b1, 2'd3);
    waitUntil(c + 128);
    checkOutput("code3_held", {30'd0, err_code_o}, 32'd3);

    // Second REQ during LOAD_M must not disturb the stream or add a pulse
    progdone_i = 2'b11;
    locked_i   = 2'b11;
    applyStimulus(2'd1, 8'd35, 8'd8, c);
    pushStream(c, 2'd1, D_DIV8, M_MUL35, 10);
    pushEvt(c + 27, 1'b0, 2'd0);
    waitUntil(c + 15);
    ch_sel_i = 2'd0;
    mult_i   = 8'd100;
    div_i    = 8'd50;
    req_i    = 1'b1;
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
    waitUntil(c + 32);

    // Reset during LOAD_D bit 5 aborts immediately
    progdone_i = 2'b00;
    locked_i   = 2'b00;
    applyStimulus(2'd1, 8'd35, 8'd8, c);
    pushStream(c, 2'd1, D_DIV8, M_MUL35, 5);
    waitUntil(c + 7);
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("abort_progen", {30'd0, progen_o}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("abort_code", {30'd0, err_code_o}, 32'd0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    r = cycleCnt;
    waitUntil(r + 2);

    // Fresh request after release completes normally
    progdone_i = 2'b11;
    locked_i   = 2'b11;
    applyStimulus(2'd0, 8'd2, 8'd1, c);
    pushStream(c, 2'd0, D_DIV1, M_MUL2, 10);
    pushEvt(c + 27, 1'b0, 2'd0);
    waitUntil(c + 32);

    checkOutput("evt_queue_empty", evtQ.size(), 32'd0);
    checkOutput("bit_queue_empty", bitQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/clkgen_prog_ctrl.md
CLKGEN_PROG_CTRL -- requirements
Module: clkgen_prog_ctrl

Interface
REQ-001: Parameter NUM_CH, default 2, sets the number of DCM_CLKGEN channels driven (legal range 1..4).
REQ-002: Parameter TIMEOUT, default 65535, sets the CLK cycles allowed per wait state before an error is raised (16-bit counter).
REQ-003: CLK  input  1  system clock; it also drives PROGCLK of every attached DCM_CLKGEN.
REQ-004: RST_N  input  1  asynchronous active-low reset.
REQ-005: REQ  input  1  program request, sampled only in IDLE.
REQ-006: CH_SEL  input  2  target channel index.
REQ-007: MULT  input  8  desired M value (legal range 2..255).
REQ-008: DIV  input  8  desired D value (legal range 1..255).
REQ-009: BUSY  output  1  high while the request is in progress (every state except IDLE).
REQ-010: DONE  output  1  one-cycle success pulse.
REQ-011: ERR  output  1  one-cycle failure pulse.
REQ-012: ERR_CODE  output  2  error cause, held until the next accepted REQ.
REQ-013: PROGEN  output  NUM_CH  per-channel program enable.
REQ-014: PROGDATA  output  1  serial data, shared by all channels.
REQ-015: PROGDONE  input  NUM_CH  per-channel PROGDONE from DCM_CLKGEN.
REQ-016: LOCKED  input  NUM_CH  per-channel LOCKED from DCM_CLKGEN.

Function
REQ-017: Accept REQ=1 only in IDLE; latch CH_SEL, MULT and DIV on that edge; move to CHK; BUSY=1 from the next cycle.
REQ-018: Ignore REQ while BUSY=1; latched values do not change.
REQ-019: CHK (1 cycle) sets ERR_CODE=1, pulses ERR and returns to IDLE when MULT<2, DIV==0 or CH_SEL>=NUM_CH; otherwise go to LOAD_D.
REQ-020: LOAD_D (10 cycles) holds PROGEN[ch]=1 and drives PROGDATA = 1, 0, then (DIV-1)[0]..[7], LSB first.
REQ-021: GAP1 (1 cycle) holds PROGEN[ch]=0 and PROGDATA=0.
REQ-022: LOAD_M (10 cycles) holds PROGEN[ch]=1 and drives PROGDATA = 1, 1, then (MULT-1)[0]..[7], LSB first.
REQ-023: GAP2 (1 cycle) drives PROGEN=0; GO (1 cycle) drives PROGEN[ch]=1 and PROGDATA=0.
REQ-024: The PROGEN bits of non-selected channels stay 0 at all times.
REQ-025: WAIT_DONE waits for PROGDONE[ch]=1, then goes to WAIT_LOCK.
REQ-026: WAIT_DONE sets ERR_CODE=2, pulses ERR and returns to IDLE after TIMEOUT cycles without PROGDONE.
REQ-027: WAIT_LOCK waits for LOCKED[ch]=1, then pulses DONE, sets ERR_CODE=0 and returns to IDLE.
REQ-028: WAIT_LOCK sets ERR_CODE=3, pulses ERR and returns to IDLE after TIMEOUT cycles without LOCKED.
REQ-029: The timeout counter clears on entry to each wait state; a condition met in the same cycle the count reaches TIMEOUT counts as success.
REQ-030: PROGEN high time from CHK exit to the end of GO is exactly 21 cycles, within a 23-cycle window.
REQ-031: DONE and ERR are mutually exclusive and both are registered outputs.
REQ-032: BUSY falls in the same cycle that DONE or ERR is high; a new REQ is accepted on the following cycle.

Reset
REQ-033: RST_N=0 asynchronously forces IDLE with BUSY=0, DONE=0, ERR=0, ERR_CODE=0, PROGEN=0, PROGDATA=0 and counters cleared.
REQ-034: Reset asserted mid-sequence aborts the sequence immediately, with no DONE or ERR pulse.
REQ-035: Reset release is synchronised internally; the first REQ is accepted no earlier than 2 cycles after release.

Verification
REQ-036: NUM_CH=2, REQ with CH_SEL=1, MULT=35, DIV=8 -> PROGDATA on PROGEN[1] = 1,0,1,1,1,0,0,0,0,0 | gap | 1,1,0,1,0,0,0,1,0,0 | gap | 0; PROGEN[0]=0 throughout.
REQ-037: PROGDONE[1] asserted 5 cycles after GO and LOCKED[1] 20 cycles later -> a single DONE pulse with ERR_CODE=0; REQ at the DONE cycle+1 is accepted.
REQ-038: MULT=1, or DIV=0, or CH_SEL=2 with NUM_CH=2 -> ERR pulse 2 cycles after REQ with ERR_CODE=1; PROGEN never asserted.
REQ-039: TIMEOUT=100 with PROGDONE held 0 -> ERR with ERR_CODE=2 exactly 100 cycles after WAIT_DONE entry; same bench with PROGDONE=1 and LOCKED=0 -> ERR_CODE=3.
REQ-040: REQ pulsed again during LOAD_M with different MULT -> serial stream unchanged; only one completion pulse.
REQ-041: RST_N=0 during LOAD_D bit 5 -> PROGEN=0 in the same cycle (asynchronous); no DONE or ERR; a fresh REQ after release completes normally.
